// File: rtl/i2c_slave_io_expander.sv
// I2C slave exposing N_PORTS 8-bit output latches (write) and input ports (read),
// with glitch-filtered bus inputs and an input-change interrupt.
module i2c_slave_io_expander #(
    parameter int N_PORTS  = 2,
    parameter int FILT_LEN = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic                   sda_oe,
    input  logic [6:0]             adr,
    output logic [8*N_PORTS-1:0]   io_out,
    input  logic [8*N_PORTS-1:0]   io_in,
    output logic                   int_n,
    output logic                   busy
);
    localparam int W = 8 * N_PORTS;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    // Bit 1 carries SCL, bit 0 carries SDA.
    logic [1:0] bus_s1_q, bus_s2_q, filt_q, filt_p_q;
    logic [2:0] fcnt_q [2];
    logic [W-1:0] io_s1_q, io_s2_q;

    state_t       state_q, state_d;
    logic [7:0]   shift_q, shift_d;
    logic [3:0]   bitcnt_q, bitcnt_d;
    logic [1:0]   ptr_q, ptr_d, ptr_next;
    logic [W-1:0] io_out_q, io_out_d, snap_q, snap_d;
    logic         sda_oe_q, sda_oe_d, int_n_q, int_n_d, busy_q, busy_d;
    logic         scl_rise, scl_fall, start_det, stop_det, sda_f;
    logic [7:0]   rd_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_s1_q <= '1;
            bus_s2_q <= '1;
            filt_q   <= '1;
            filt_p_q <= '1;
            fcnt_q   <= '{default: '0};
            io_s1_q  <= '1;
            io_s2_q  <= '1;
        end else begin
            bus_s1_q <= {scl_i, sda_i};
            bus_s2_q <= bus_s1_q;
            filt_p_q <= filt_q;
            io_s1_q  <= io_in;
            io_s2_q  <= io_s1_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (bus_s2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == 3'(FILT_LEN - 1)) begin
                    filt_q[i] <= bus_s2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 3'd1;
                end
            end
        end
    end

    assign sda_f     = filt_q[0];
    assign scl_rise  =  filt_q[1] & ~filt_p_q[1];
    assign scl_fall  = ~filt_q[1] &  filt_p_q[1];
    assign start_det = filt_q[1] & filt_p_q[1] &  filt_p_q[0] & ~filt_q[0];
    assign stop_det  = filt_q[1] & filt_p_q[1] & ~filt_p_q[0] &  filt_q[0];
    assign ptr_next  = (ptr_q == 2'(N_PORTS - 1)) ? '0 : ptr_q + 2'd1;
    assign rd_byte   = io_s2_q[{ptr_q, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            ptr_q    <= '0;
            io_out_q <= '1;
            snap_q   <= '1;
            sda_oe_q <= 1'b0;
            int_n_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            ptr_q    <= ptr_d;
            io_out_q <= io_out_d;
            snap_q   <= snap_d;
            sda_oe_q <= sda_oe_d;
            int_n_q  <= int_n_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        ptr_d    = ptr_q;
        io_out_d = io_out_q;
        snap_d   = snap_q;
        busy_d   = busy_q;
        if (start_det) begin
            state_d  = ADDR;
            bitcnt_d = '0;
            ptr_d    = '0;
            busy_d   = 1'b1;
        end else if (stop_det) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, WR_DATA: begin
                    if (scl_rise && bitcnt_q < 4'd8) begin
                        shift_d  = {shift_q[6:0], sda_f};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                    if (scl_fall && bitcnt_q == 4'd8) begin
                        if (state_q == WR_DATA)      state_d = WR_ACK;
                        else if (shift_q[7:1] == adr) state_d = ADDR_ACK;
                        else                          state_d = IGNORE;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bitcnt_d = '0;
                        if (shift_q[0]) begin
                            state_d = RD_DATA;
                            shift_d = rd_byte;
                            snap_d[{ptr_q, 3'b000} +: 8] = rd_byte;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_rise) begin
                        io_out_d[{ptr_q, 3'b000} +: 8] = shift_q;
                        ptr_d = ptr_next;
                    end
                    if (scl_fall) begin
                        state_d  = WR_DATA;
                        bitcnt_d = '0;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd7) begin
                            state_d  = RD_ACK;
                            bitcnt_d = '0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    // bitcnt==8 marks that the master ACKed on this ninth clock.
                    if (scl_rise) begin
                        if (!sda_f) begin
                            ptr_d    = ptr_next;
                            bitcnt_d = 4'd8;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                    if (scl_fall && bitcnt_q == 4'd8) begin
                        state_d  = RD_DATA;
                        bitcnt_d = '0;
                        shift_d  = rd_byte;
                        snap_d[{ptr_q, 3'b000} +: 8] = rd_byte;
                    end
                end
                default: ;
            endcase
        end
    end

    // SDA drive follows the next state so it changes on the clk after the SCL fall.
    always_comb begin
        case (state_d)
            ADDR_ACK, WR_ACK: sda_oe_d = 1'b1;
            RD_DATA:          sda_oe_d = ~shift_d[7];
            default:          sda_oe_d = 1'b0;
        endcase
        int_n_d = ~|(io_s2_q ^ snap_q);
    end

    assign sda_oe = sda_oe_q;
    assign io_out = io_out_q;
    assign int_n  = int_n_q;
    assign busy   = busy_q;
endmodule
